// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg -- shared definitions for the systolic-array feeder blocks.
//
// Contents:
//   loader_state_t  : state encoding of the memA loader FSM
//   run_cycles()    : length of the fill+compute+drain window for a DIMxDIM
//                     array (the skewed diagonals need 3*DIM-2 cycles)
//   DEF_*           : default element widths and array dimension
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_BITS_C  = 16;
  localparam int DEF_DIM     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } loader_state_t;

  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/sa_tile_counter.sv
// ---------------------------------------------------------------------------
// sa_tile_counter -- parameterised up-counter with clear, increment enable
// and terminal-count flag.
//
// Ports:
//   clk   : clock, state on posedge
//   rst   : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear, has priority over inc
//   inc   : count up by one
//   cnt_o : current count
//   tc_o  : high while cnt_o == TC_VAL
// ---------------------------------------------------------------------------
module sa_tile_counter #(
  parameter int WIDTH  = 4,
  parameter int TC_VAL = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == WIDTH'(TC_VAL));

endmodule

// File: rtl/mema_loader.sv
// ---------------------------------------------------------------------------
// mema_loader -- upstream feeder for the A-operand skew buffer (memA).
//
// Accepts DIM rows of the A tile over a valid/ready handshake, writes each
// one into memA (en=1, WrEn=1) the cycle after it is accepted, then keeps
// memA enabled with zero data for RUN_CYC cycles so the skewed diagonals
// drain through the array, and finally pulses done.
//
// Ports:
//   clk      : clock, all state on posedge
//   rst      : asynchronous active-high reset
//   abort    : synchronous abort, back to IDLE from any state
//   in_valid : host row valid
//   in_ready : loader can take a row this cycle (combinational)
//   in_row   : packed row, element i at [i*BITS_AB +: BITS_AB]
//   en       : memA enable            (registered)
//   WrEn     : memA write enable      (registered)
//   Ain      : row data to memA       (registered)
//   busy     : high in LOAD or RUN    (registered)
//   done     : one-cycle pulse at the end of RUN (registered)
// ---------------------------------------------------------------------------
module mema_loader
  import sa_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*BITS_AB-1:0]    in_row,
  output logic                      en,
  output logic                      WrEn,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic                      busy,
  output logic                      done
);

  localparam int ROWBITS = $clog2(DIM);
  localparam int ROWCW   = ROWBITS + 1;
  localparam int RUN_CYC = run_cycles(DIM);
  localparam int RUNW    = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;

  loader_state_t             state_q;
  logic                      en_q;
  logic                      wren_q;
  logic                      busy_q;
  logic                      done_q;
  logic signed [BITS_AB-1:0] ain_q [DIM];

  logic signed [BITS_AB-1:0] row_elem [DIM];

  logic [ROWCW-1:0] row_cnt;
  logic             row_last;
  logic             row_clr;
  logic             row_inc;
  logic [RUNW-1:0]  run_cnt;
  logic             run_last;
  logic             run_clr;
  logic             run_inc;

  logic accept;
  logic row_bad;
  logic run_bad;

  // Unpack the host row into per-element signed lanes.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_unpack
    assign row_elem[gi] = in_row[gi*BITS_AB +: BITS_AB];
    assign Ain[gi]      = ain_q[gi];
  end

  // Counters that can only reach these values through corruption; seeing
  // one sends the FSM back to IDLE rather than running off the end.
  assign row_bad = (row_cnt >= ROWCW'(DIM));
  assign run_bad = (run_cnt >= RUNW'(RUN_CYC));

  // in_ready never looks at in_valid, so the handshake has no comb loop.
  always_comb begin
    in_ready = 1'b0;
    if (!abort) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        LOAD:    in_ready = !row_bad;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // Counter control.
  always_comb begin
    row_clr = 1'b0;
    row_inc = 1'b0;
    run_clr = 1'b0;
    run_inc = 1'b0;
    if (abort) begin
      row_clr = 1'b1;
      run_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          row_inc = accept;
        end
        LOAD: begin
          if (row_bad) begin
            row_clr = 1'b1;
          end else begin
            row_inc = accept;
          end
        end
        RUN: begin
          // Clear at the terminal count instead of wrapping so run_cnt is
          // already zero when DONE is entered.
          if (run_last || run_bad) begin
            run_clr = 1'b1;
          end else begin
            run_inc = 1'b1;
          end
          if (run_bad) begin
            row_clr = 1'b1;
          end
        end
        default: begin
          row_clr = 1'b1;
          run_clr = 1'b1;
        end
      endcase
    end
  end

  sa_tile_counter #(
    .WIDTH  (ROWCW),
    .TC_VAL (DIM - 1)
  ) u_row_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (row_clr),
    .inc   (row_inc),
    .cnt_o (row_cnt),
    .tc_o  (row_last)
  );

  sa_tile_counter #(
    .WIDTH  (RUNW),
    .TC_VAL (RUN_CYC - 1)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_clr),
    .inc   (run_inc),
    .cnt_o (run_cnt),
    .tc_o  (run_last)
  );

  // FSM and registered outputs. The outputs describe what memA sees in the
  // cycle after each edge, so the last RUN output cycle coincides with the
  // DONE state and the done pulse coincides with the first IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        ain_q[i] <= '0;
      end
    end else if (abort) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        ain_q[i] <= '0;
      end
    end else begin
      en_q   <= 1'b0;
      wren_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (state_q == LOAD && row_bad) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
              ain_q[i] <= '0;
            end
          end else if (accept) begin
            en_q    <= 1'b1;
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= row_last ? RUN : LOAD;
            for (int i = 0; i < DIM; i++) begin
              ain_q[i] <= row_elem[i];
            end
          end else begin
            // No accept: memA holds, Ain keeps its last value.
            busy_q <= (state_q == LOAD);
          end
        end
        RUN: begin
          for (int i = 0; i < DIM; i++) begin
            ain_q[i] <= '0;
          end
          if (run_bad) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            en_q    <= 1'b1;
            state_q <= run_last ? DONE : RUN;
            busy_q  <= !run_last;
          end
        end
        default: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign en   = en_q;
  assign WrEn = wren_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mema_loader.sv
// ---------------------------------------------------------------------------
// tb_mema_loader -- directed, table-driven bench for mema_loader (DIM=8,
// BITS_AB=8). Each table record gives the inputs for one cycle and the
// outputs expected during that cycle (registered outputs from the previous
// edge, in_ready from the current state/abort).
// ---------------------------------------------------------------------------
module tb_mema_loader;

  localparam int DIM = 8;
  localparam int B   = 8;
  localparam int RW  = DIM * B;
  localparam int RUN = 3 * DIM - 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row = '0;
  logic          en;
  logic          WrEn;
  logic signed [B-1:0] Ain [DIM];
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mema_loader #(
    .BITS_AB (B),
    .DIM     (DIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .en       (en),
    .WrEn     (WrEn),
    .Ain      (Ain),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    bit            valid;
    bit            abrt;
    logic [RW-1:0] row;
    bit            rdy;
    bit            en;
    bit            wr;
    bit            busy;
    bit            done;
    logic [RW-1:0] ain;
  } vec_t;

  vec_t          vec [320];
  int            nvec = 0;
  logic [RW-1:0] rows [DIM];

  localparam logic [RW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [RW-1:0] ZERO = '0;

  function automatic logic [RW-1:0] flat_ain();
    logic [RW-1:0] f;
    for (int i = 0; i < DIM; i++) f[i*B +: B] = Ain[i];
    return f;
  endfunction

  function automatic logic [RW-1:0] inc_row(input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*B +: B] = 8'(r * 8 + i);
    return v;
  endfunction

  // Elements alternate -128 / -1; odd rows start with -1.
  function automatic logic [RW-1:0] neg_row(input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*B +: B] = (((i + r) % 2) == 0) ? 8'h80 : 8'hFF;
    return v;
  endfunction

  task automatic add(input bit v, input bit a, input logic [RW-1:0] r,
                     input bit rdy, input bit e, input bit w, input bit bz,
                     input bit dn, input logic [RW-1:0] ain);
    vec[nvec] = '{valid: v, abrt: a, row: r, rdy: rdy, en: e, wr: w,
                  busy: bz, done: dn, ain: ain};
    nvec++;
  endtask

  task automatic set_rows(input bit neg);
    for (int r = 0; r < DIM; r++) rows[r] = neg ? neg_row(r) : inc_row(r);
  endtask

  // Eight back-to-back accepts starting from idle with Ain==0.
  task automatic add_load();
    for (int k = 0; k < DIM; k++)
      add(1, 0, rows[k], 1, k > 0, k > 0, k > 0, 0, (k > 0) ? rows[k-1] : ZERO);
  endtask

  // Last write cycle, RUN_CYC-1 more run cycles, DONE-state cycle.
  task automatic add_tail(input bit hold);
    add(hold, 0, JUNK, 0, 1, 1, 1, 0, rows[DIM-1]);
    for (int k = 0; k < RUN - 1; k++) add(hold, 0, JUNK, 0, 1, 0, 1, 0, ZERO);
    add(hold, 0, JUNK, 0, 1, 0, 0, 0, ZERO);
  endtask

  task automatic chk(input string nm, input int idx, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // ---------------- build vector table ----------------
    // 1: back-to-back load, incrementing data
    set_rows(0);
    add_load();
    add_tail(0);
    add(0, 0, ZERO, 1, 0, 0, 0, 1, ZERO);   // done pulse, first IDLE cycle
    add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // 2: negative data, in_valid held through RUN/DONE, next row 0 taken on
    //    the first IDLE cycle, then aborted out of LOAD
    set_rows(1);
    add_load();
    add_tail(1);
    add(1, 0, inc_row(0), 1, 0, 0, 0, 1, ZERO);
    add(0, 1, ZERO, 0, 1, 1, 1, 0, inc_row(0));
    add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // 3: bubbled load (1,0,1,0,...)
    set_rows(0);
    for (int k = 0; k < DIM; k++) begin
      add(1, 0, rows[k], 1, 0, 0, k > 0, 0, (k > 0) ? rows[k-1] : ZERO);
      if (k < DIM - 1) add(0, 0, JUNK, 1, 1, 1, 1, 0, rows[k]);
    end
    add_tail(0);
    add(0, 0, ZERO, 1, 0, 0, 0, 1, ZERO);
    add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // 4a: abort on what would be the 4th accept
    for (int k = 0; k < 3; k++)
      add(1, 0, rows[k], 1, k > 0, k > 0, k > 0, 0, (k > 0) ? rows[k-1] : ZERO);
    add(1, 1, rows[3], 0, 1, 1, 1, 0, rows[2]);
    add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // 4b: abort on the 10th RUN cycle, no done afterwards
    add_load();
    add(0, 0, ZERO, 0, 1, 1, 1, 0, rows[DIM-1]);
    for (int k = 0; k < 9; k++) add(0, 0, ZERO, 0, 1, 0, 1, 0, ZERO);
    add(0, 1, ZERO, 0, 1, 0, 1, 0, ZERO);
    for (int k = 0; k < 3; k++) add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // 4c: a fresh tile completes normally
    add_load();
    add_tail(0);
    add(0, 0, ZERO, 1, 0, 0, 0, 1, ZERO);
    add(0, 0, ZERO, 1, 0, 0, 0, 0, ZERO);

    // ---------------- reset state ----------------
    #2;
    chk("rst_en",   -1, 64'(en),   0);
    chk("rst_wren", -1, 64'(WrEn), 0);
    chk("rst_busy", -1, 64'(busy), 0);
    chk("rst_done", -1, 64'(done), 0);
    chk("rst_ain",  -1, flat_ain(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- apply table ----------------
    for (int i = 0; i < nvec; i++) begin
      in_valid = vec[i].valid;
      abort    = vec[i].abrt;
      in_row   = vec[i].row;
      #1;
      $display("vec %0d v=%b ab=%b rdy=%b en=%b wr=%b busy=%b done=%b ain=%h",
               i, in_valid, abort, in_ready, en, WrEn, busy, done, flat_ain());
      chk("in_ready", i, 64'(in_ready), 64'(vec[i].rdy));
      chk("en",       i, 64'(en),       64'(vec[i].en));
      chk("WrEn",     i, 64'(WrEn),     64'(vec[i].wr));
      chk("busy",     i, 64'(busy),     64'(vec[i].busy));
      chk("done",     i, 64'(done),     64'(vec[i].done));
      chk("Ain",      i, flat_ain(),    vec[i].ain);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    abort    = 1'b0;

    // ---------------- signed data and async reset mid-RUN ----------------
    for (int r = 0; r < DIM; r++) begin
      in_valid = 1'b1;
      in_row   = neg_row(r);
      @(posedge clk);
      #1;
      if (r == 0) begin
        checks++;
        if ($signed(Ain[0]) != -128 || $signed(Ain[1]) != -1) begin
          errors++;
          $display("FAIL signed_ain: got %0d,%0d expected -128,-1",
                   $signed(Ain[0]), $signed(Ain[1]));
        end
      end
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_en",   -2, 64'(en),   1);
    chk("pre_rst_busy", -2, 64'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_en",   -2, 64'(en),   0);
    chk("arst_wren", -2, 64'(WrEn), 0);
    chk("arst_done", -2, 64'(done), 0);
    chk("arst_busy", -2, 64'(busy), 0);
    chk("arst_ain",  -2, flat_ain(), 0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_ready", -2, 64'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("post_rst_en",   -2, 64'(en),   0);
    chk("post_rst_done", -2, 64'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
